// File: rtl/data_memory_ls.sv
// Load/store data memory for the MEM stage: sized stores, sign/zero-extended loads,
// misalignment suppression, a post-reset clear sweep and a halted-core debug port.
module data_memory_ls #(
    parameter int DEPTH          = 1024,
    parameter int DBG_ADDR_W     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [2:0]            funct3,
    output logic [31:0]           read_data,
    output logic                  misaligned,
    output logic                  mem_busy,
    output logic [31:0]           data_mem0,
    input  logic                  dbg_enable,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_rw,
    input  logic [DBG_ADDR_W-1:0] dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_resp_valid,
    input  logic                  dbg_resp_ready,
    output logic [DBG_ADDR_W-1:0] dbg_resp_addr,
    output logic [31:0]           dbg_resp_data,
    output logic                  dbg_resp_err,
    output logic [1:0]            fsm_state
);

    localparam int ADDR_BITS = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] clr_cnt;
    logic [ADDR_BITS-1:0] cpu_idx;
    logic [ADDR_BITS-1:0] dbg_idx;
    logic [31:0]          cur_word;
    logic [31:0]          dbg_word;
    logic [31:0]          dbg_addr_ext;
    logic                 dbg_in_range;
    logic                 dbg_accept;
    logic                 is_half;
    logic                 is_word;
    logic                 addr_mis;
    logic                 busy;
    logic                 store_en;
    logic [31:0]          store_word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic                 unused_bits;

    // Bits above the word index are deliberately ignored.
    assign unused_bits = &{1'b0, address[31:ADDR_BITS+2]};

    assign busy      = (state_q == ST_CLEAR);
    assign mem_busy  = busy;
    assign fsm_state = state_q;
    assign data_mem0 = mem[0];

    assign cpu_idx  = address[ADDR_BITS+1:2];
    assign cur_word = mem[cpu_idx];

    // ------------------------------------------------------------------
    // Access size decode and misalignment
    // ------------------------------------------------------------------
    assign is_half    = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign is_word    = (funct3 == 3'b010);
    assign addr_mis   = (is_half & address[0]) | (is_word & (address[1:0] != 2'b00));
    assign misaligned = (MemRead | MemWrite) & addr_mis;

    // ------------------------------------------------------------------
    // Store merge: unwritten lanes keep the current word
    // ------------------------------------------------------------------
    always_comb begin
        store_word = cur_word;
        store_en   = 1'b0;
        case (funct3)
            3'b000: begin
                store_word[{address[1:0], 3'b000} +: 8] = write_data[7:0];
                store_en = 1'b1;
            end
            3'b001: begin
                store_word[{address[1], 4'b0000} +: 16] = write_data[15:0];
                store_en = 1'b1;
            end
            3'b010: begin
                store_word = write_data;
                store_en   = 1'b1;
            end
            default: begin
                store_word = cur_word;
                store_en   = 1'b0;
            end
        endcase
        store_en = store_en & MemWrite & ~addr_mis & ~busy & reset_n;
    end

    // ------------------------------------------------------------------
    // Load extract and extension
    // ------------------------------------------------------------------
    assign byte_sel = cur_word[{address[1:0], 3'b000} +: 8];
    assign half_sel = cur_word[{address[1], 4'b0000} +: 16];

    always_comb begin
        read_data = 32'h0;
        if (MemRead && !busy && !addr_mis) begin
            case (funct3)
                3'b000:  read_data = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  read_data = {24'h0, byte_sel};
                3'b001:  read_data = {{16{half_sel[15]}}, half_sel};
                3'b101:  read_data = {16'h0, half_sel};
                3'b010:  read_data = cur_word;
                default: read_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Debug port. A request transfers on an edge where dbg_req_valid and
    // dbg_req_ready are both high; the response is held stable from the next
    // cycle until an edge with dbg_resp_valid and dbg_resp_ready both high.
    // Neither valid may depend on its ready. The CPU store path wins: ready
    // is low whenever MemWrite is high.
    // ------------------------------------------------------------------
    assign dbg_addr_ext  = 32'(dbg_addr);
    assign dbg_in_range  = dbg_addr_ext < 32'(DEPTH);
    assign dbg_idx       = dbg_addr_ext[ADDR_BITS-1:0];
    assign dbg_word      = mem[dbg_idx];
    assign dbg_req_ready = reset_n & (state_q == ST_IDLE) & dbg_enable & ~MemWrite;
    assign dbg_accept    = dbg_req_valid & dbg_req_ready;
    assign dbg_resp_valid = (state_q == ST_RESP);

    // ------------------------------------------------------------------
    // Memory array: sweep, CPU store and debug write are mutually exclusive
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= 32'h0;
        end else if (store_en) begin
            mem[cpu_idx] <= store_word;
        end else if (dbg_accept && dbg_rw && dbg_in_range) begin
            mem[dbg_idx] <= dbg_wdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt == '1) state_d = ST_IDLE;
            ST_IDLE:  if (dbg_accept) state_d = ST_RESP;
            ST_RESP:  if (dbg_resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sweep counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt       <= '0;
            dbg_resp_addr <= '0;
            dbg_resp_data <= 32'h0;
            dbg_resp_err  <= 1'b0;
        end else begin
            if (busy) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (dbg_accept) begin
                dbg_resp_addr <= dbg_addr;
                dbg_resp_err  <= ~dbg_in_range;
                if (!dbg_in_range) begin
                    dbg_resp_data <= 32'h0;
                end else if (dbg_rw) begin
                    dbg_resp_data <= dbg_wdata;
                end else begin
                    dbg_resp_data <= dbg_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls at DEPTH=16: sweep, sized accesses,
// misalignment, debug handshake, arbitration, errors and asynchronous reset.
module tb_data_memory_ls;

    localparam int DEPTH      = 16;
    localparam int DBG_ADDR_W = 10;

    logic                  clk;
    logic                  reset_n;
    logic [31:0]           address;
    logic [31:0]           write_data;
    logic                  MemWrite;
    logic                  MemRead;
    logic [2:0]            funct3;
    logic [31:0]           read_data;
    logic                  misaligned;
    logic                  mem_busy;
    logic [31:0]           data_mem0;
    logic                  dbg_enable;
    logic                  dbg_req_valid;
    logic                  dbg_req_ready;
    logic                  dbg_rw;
    logic [DBG_ADDR_W-1:0] dbg_addr;
    logic [31:0]           dbg_wdata;
    logic                  dbg_resp_valid;
    logic                  dbg_resp_ready;
    logic [DBG_ADDR_W-1:0] dbg_resp_addr;
    logic [31:0]           dbg_resp_data;
    logic                  dbg_resp_err;
    logic [1:0]            fsm_state;

    int checks   = 0;
    int failures = 0;

    data_memory_ls #(
        .DEPTH(DEPTH),
        .DBG_ADDR_W(DBG_ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .write_data(write_data),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .funct3(funct3),
        .read_data(read_data),
        .misaligned(misaligned),
        .mem_busy(mem_busy),
        .data_mem0(data_mem0),
        .dbg_enable(dbg_enable),
        .dbg_req_valid(dbg_req_valid),
        .dbg_req_ready(dbg_req_ready),
        .dbg_rw(dbg_rw),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_resp_valid(dbg_resp_valid),
        .dbg_resp_ready(dbg_resp_ready),
        .dbg_resp_addr(dbg_resp_addr),
        .dbg_resp_data(dbg_resp_data),
        .dbg_resp_err(dbg_resp_err),
        .fsm_state(fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        @(negedge clk);
        address = a; write_data = d; funct3 = f3; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic cpu_load(input logic [31:0] a, input logic [2:0] f3,
                            output logic [31:0] rd, output logic mis);
        @(negedge clk);
        address = a; funct3 = f3; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        rd  = read_data;
        mis = misaligned;
        MemRead = 1'b0;
    endtask

    // Returns one tick after the acceptance edge's following negedge.
    task automatic dbg_xact(input logic rw, input logic [DBG_ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        dbg_enable = 1'b1; dbg_req_valid = 1'b1; dbg_rw = rw; dbg_addr = a; dbg_wdata = d;
        @(negedge clk);
        dbg_req_valid = 1'b0;
        #1;
    endtask

    task automatic dbg_finish();
        dbg_resp_ready = 1'b1;
        @(negedge clk);
        dbg_resp_ready = 1'b0;
    endtask

    task automatic release_and_count(output int n);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (mem_busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        dbg_enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b0 || dbg_resp_addr !== '0 || dbg_resp_data !== 32'h0 ||
            dbg_resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp: valid=%b addr=%0d data=%h err=%b, required all zero",
                     dbg_resp_valid, dbg_resp_addr, dbg_resp_data, dbg_resp_err);
        end
        checks++;
        if (dbg_req_ready !== 1'b0 || mem_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b busy=%b, required ready=0 busy=1",
                     dbg_req_ready, mem_busy);
        end
        dbg_enable = 1'b0;
        release_and_count(n);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL initial_sweep_len: got %0d cycles, required %0d", n, DEPTH);
        end
    endtask

    task automatic test_reset_sweep();
        int n;
        logic [31:0] rd;
        logic mis;
        for (int i = 0; i < DEPTH; i++) begin
            cpu_store(32'(i * 4), $urandom(), 3'b010);
        end
        @(negedge clk);
        reset_n = 1'b0;
        address = 32'h0; write_data = 32'hFFFF_FFFF; funct3 = 3'b010;
        MemWrite = 1'b1; MemRead = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0 || mem_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_read: read_data=%h busy=%b, required 0 and 1", read_data, mem_busy);
        end
        n = 0;
        while (mem_busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        MemWrite = 1'b0; MemRead = 1'b0;
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL sweep_len: got %0d cycles, required %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cpu_load(32'(i * 4), 3'b010, rd, mis);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL sweep_word%0d: got %h, required 00000000", i, rd);
            end
        end
        checks++;
        if (data_mem0 !== 32'h0) begin
            failures++;
            $display("FAIL sweep_mem0: got %h, required 00000000", data_mem0);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic mis;
        cpu_store(32'h8, 32'h1122_3344, 3'b010);
        cpu_store(32'h9, 32'h0000_00AA, 3'b000);
        cpu_store(32'hA, 32'h0000_BEEF, 3'b001);
        cpu_store(32'h8, 32'hDEAD_BEEF, 3'b011);
        cpu_load(32'h8, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'hBEEF_AA44) begin
            failures++; $display("FAIL lw_merged: got %h, required beefaa44", rd);
        end
        cpu_load(32'h9, 3'b000, rd, mis);
        checks++;
        if (rd !== 32'hFFFF_FFAA) begin
            failures++; $display("FAIL lb: got %h, required ffffffaa", rd);
        end
        cpu_load(32'h9, 3'b100, rd, mis);
        checks++;
        if (rd !== 32'h0000_00AA) begin
            failures++; $display("FAIL lbu: got %h, required 000000aa", rd);
        end
        cpu_load(32'hA, 3'b001, rd, mis);
        checks++;
        if (rd !== 32'hFFFF_BEEF) begin
            failures++; $display("FAIL lh: got %h, required ffffbeef", rd);
        end
        cpu_load(32'hA, 3'b101, rd, mis);
        checks++;
        if (rd !== 32'h0000_BEEF) begin
            failures++; $display("FAIL lhu: got %h, required 0000beef", rd);
        end
        cpu_load(32'h8, 3'b000, rd, mis);
        checks++;
        if (rd !== 32'h0000_0044) begin
            failures++; $display("FAIL lb_pos: got %h, required 00000044", rd);
        end
        cpu_load(32'h8, 3'b011, rd, mis);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL load_bad_f3: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic mis;
        cpu_store(32'h4, 32'h5566_7788, 3'b010);
        @(negedge clk);
        address = 32'h6; write_data = 32'h1234_5678; funct3 = 3'b010; MemWrite = 1'b1;
        #1;
        checks++;
        if (misaligned !== 1'b1) begin
            failures++; $display("FAIL sw_mis_flag: got %b, required 1", misaligned);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        checks++;
        if (misaligned !== 1'b0) begin
            failures++; $display("FAIL mis_idle: got %b, required 0", misaligned);
        end
        cpu_load(32'h4, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'h5566_7788) begin
            failures++; $display("FAIL sw_mis_nowrite: got %h, required 55667788", rd);
        end
        cpu_load(32'h5, 3'b001, rd, mis);
        checks++;
        if (mis !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL lh_mis: mis=%b data=%h, required 1 and 00000000", mis, rd);
        end
        cpu_load(32'h5, 3'b000, rd, mis);
        checks++;
        if (mis !== 1'b0 || rd !== 32'h0000_0077) begin
            failures++; $display("FAIL lb_aligned: mis=%b data=%h, required 0 and 00000077", mis, rd);
        end
    endtask

    task automatic test_debug_handshake();
        logic [31:0] rd;
        logic mis;
        dbg_resp_ready = 1'b0;
        @(negedge clk);
        dbg_enable = 1'b1; dbg_req_valid = 1'b1; dbg_rw = 1'b1; dbg_addr = 10'd3;
        dbg_wdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (dbg_req_ready !== 1'b1) begin
            failures++; $display("FAIL dbg_ready_idle: got %b, required 1", dbg_req_ready);
        end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (dbg_resp_valid !== 1'b1 || dbg_resp_addr !== 10'd3 ||
                dbg_resp_data !== 32'hCAFE_F00D || dbg_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL dbg_hold%0d: valid=%b addr=%0d data=%h ready=%b, required 1 3 cafef00d 0",
                         c, dbg_resp_valid, dbg_resp_addr, dbg_resp_data, dbg_req_ready);
            end
            @(negedge clk);
        end
        dbg_finish();
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b0 || dbg_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL dbg_release: valid=%b ready=%b, required 0 and 1", dbg_resp_valid, dbg_req_ready);
        end
        dbg_xact(1'b0, 10'd3, 32'h0);
        checks++;
        if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== 32'hCAFE_F00D || dbg_resp_err !== 1'b0) begin
            failures++;
            $display("FAIL dbg_read: valid=%b data=%h err=%b, required 1 cafef00d 0",
                     dbg_resp_valid, dbg_resp_data, dbg_resp_err);
        end
        dbg_finish();
        cpu_load(32'hC, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL dbg_write_cpu_view: got %h, required cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back();
        dbg_resp_ready = 1'b1;
        @(negedge clk);
        dbg_enable = 1'b1; dbg_req_valid = 1'b1; dbg_rw = 1'b0; dbg_addr = 10'd2;
        #1;
        checks++;
        if (dbg_req_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready0: got %b, required 1", dbg_req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b1 || dbg_req_ready !== 1'b0 || dbg_resp_data !== 32'hBEEF_AA44) begin
            failures++;
            $display("FAIL b2b_first: valid=%b ready=%b data=%h, required 1 0 beefaa44",
                     dbg_resp_valid, dbg_req_ready, dbg_resp_data);
        end
        dbg_addr = 10'd3;
        @(negedge clk);
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b0 || dbg_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: valid=%b ready=%b, required 0 and 1", dbg_resp_valid, dbg_req_ready);
        end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL b2b_second: valid=%b data=%h, required 1 cafef00d", dbg_resp_valid, dbg_resp_data);
        end
        @(negedge clk);
        dbg_resp_ready = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [31:0] rd;
        logic mis;
        @(negedge clk);
        dbg_enable = 1'b1; dbg_req_valid = 1'b1; dbg_rw = 1'b1; dbg_addr = 10'd7;
        dbg_wdata = 32'hFFFF_FFFF;
        address = 32'h1C; write_data = 32'h0BAD_F00D; funct3 = 3'b010; MemWrite = 1'b1;
        #1;
        checks++;
        if (dbg_req_ready !== 1'b0) begin
            failures++; $display("FAIL arb_ready: got %b, required 0", dbg_req_ready);
        end
        @(negedge clk);
        MemWrite = 1'b0; dbg_req_valid = 1'b0;
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b0) begin
            failures++; $display("FAIL arb_no_resp: got %b, required 0", dbg_resp_valid);
        end
        cpu_load(32'h1C, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL arb_cpu_write: got %h, required 0badf00d", rd);
        end
        @(negedge clk);
        dbg_enable = 1'b0; dbg_req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (dbg_req_ready !== 1'b0 || dbg_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL dbg_disabled%0d: ready=%b valid=%b, required 0 and 0",
                         c, dbg_req_ready, dbg_resp_valid);
            end
            @(negedge clk);
        end
        dbg_req_valid = 1'b0;
        cpu_load(32'h1C, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL dbg_disabled_nowrite: got %h, required 0badf00d", rd);
        end
    endtask

    task automatic test_dbg_error();
        dbg_resp_ready = 1'b0;
        dbg_xact(1'b1, 10'd0, 32'hA5A5_A5A5);
        dbg_finish();
        #1;
        checks++;
        if (data_mem0 !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL dbg_word0: got %h, required a5a5a5a5", data_mem0);
        end
        dbg_xact(1'b1, 10'(DEPTH), 32'h1234_5678);
        checks++;
        if (dbg_resp_valid !== 1'b1 || dbg_resp_err !== 1'b1 || dbg_resp_data !== 32'h0 ||
            dbg_resp_addr !== 10'(DEPTH)) begin
            failures++;
            $display("FAIL dbg_err_write: valid=%b err=%b data=%h addr=%0d, required 1 1 00000000 %0d",
                     dbg_resp_valid, dbg_resp_err, dbg_resp_data, dbg_resp_addr, DEPTH);
        end
        dbg_finish();
        #1;
        checks++;
        if (data_mem0 !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL dbg_err_nowrite: word0 %h, required a5a5a5a5", data_mem0);
        end
        dbg_xact(1'b0, 10'd20, 32'h0);
        checks++;
        if (dbg_resp_err !== 1'b1 || dbg_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL dbg_err_read: err=%b data=%h, required 1 00000000", dbg_resp_err, dbg_resp_data);
        end
        dbg_finish();
    endtask

    task automatic test_reset_mid_op();
        int n;
        logic [31:0] rd;
        logic mis;
        cpu_store(32'h3C, 32'h7777_7777, 3'b010);
        dbg_resp_ready = 1'b0;
        dbg_xact(1'b1, 10'd1, 32'h1111_1111);
        checks++;
        if (dbg_resp_valid !== 1'b1) begin
            failures++; $display("FAIL mid_in_resp: valid=%b, required 1", dbg_resp_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dbg_resp_valid !== 1'b0 || dbg_resp_addr !== '0 || dbg_resp_data !== 32'h0 ||
            mem_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_resp_reset: valid=%b addr=%0d data=%h busy=%b, required 0 0 00000000 1",
                     dbg_resp_valid, dbg_resp_addr, dbg_resp_data, mem_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_busy !== 1'b1 || dbg_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_sweep_reset: busy=%b valid=%b, required 1 and 0", mem_busy, dbg_resp_valid);
        end
        release_and_count(n);
        checks++;
        if (n != DEPTH) begin
            failures++; $display("FAIL restart_sweep_len: got %0d cycles, required %0d", n, DEPTH);
        end
        cpu_load(32'h3C, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL restart_word15: got %h, required 00000000", rd);
        end
        cpu_load(32'h4, 3'b010, rd, mis);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL restart_word1: got %h, required 00000000", rd);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        address = 32'h0; write_data = 32'h0; MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'b000;
        dbg_enable = 1'b0; dbg_req_valid = 1'b0; dbg_rw = 1'b0; dbg_addr = '0;
        dbg_wdata = 32'h0; dbg_resp_ready = 1'b0;

        test_reset();
        test_reset_sweep();
        test_byte_half();
        test_misaligned();
        test_debug_handshake();
        test_back_to_back();
        test_arbitration();
        test_dbg_error();
        test_reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_ls.md
# data_memory_ls

Parametrised load/store data memory for the pipelined RISC-V core's MEM stage, with a UART debug port. Stores can be byte, halfword or word wide. Loads are sign- or zero-extended. Misaligned accesses are detected and suppressed. A post-reset clear sweep replaces the bulk reset of every word. Debug traffic uses a valid/ready request/response handshake and is only serviced while the core is halted.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words. Power of two, ≥4. ADDR_BITS = log2(DEPTH).
- DBG_ADDR_W, 10: width of the debug word address.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset via the sweep; 0 = skip the sweep, contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address. Word index = address[ADDR_BITS+1:2]; higher bits are ignored.
- write_data  in  32  CPU store data.
- MemWrite  in  1  CPU store enable.
- MemRead  in  1  CPU load enable.
- funct3  in  3  RISC-V load/store size and sign code.
- read_data  out  32  CPU load result (combinational).
- misaligned  out  1  combinational flag: the current access is misaligned.
- mem_busy  out  1  clear sweep in progress; the core must stall.
- data_mem0  out  32  continuous copy of word 0.
- dbg_enable  in  1  core halted; debug access permitted.
- dbg_req_valid  in  1  debug request valid.
- dbg_req_ready  out  1  debug request accepted on this edge if valid.
- dbg_rw  in  1  1 = write, 0 = read.
- dbg_addr  in  DBG_ADDR_W  debug word address.
- dbg_wdata  in  32  debug write data.
- dbg_resp_valid  out  1  response pending.
- dbg_resp_ready  in  1  response consumed.
- dbg_resp_addr  out  DBG_ADDR_W  address of the completed request.
- dbg_resp_data  out  32  read data, or write data echoed back.
- dbg_resp_err  out  1  dbg_addr was ≥ DEPTH.

## Operation
- FSM states: CLEAR, IDLE, RESP. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR:
  - Writes 0 to mem[clr_cnt] each cycle and increments clr_cnt, starting from 0.
  - After writing index DEPTH-1, goes to IDLE.
  - mem_busy=1 throughout. CPU stores are ignored, read_data=0, dbg_req_ready=0.
- Stores, by funct3:
  - 000 SB: writes byte lane address[1:0] with write_data[7:0].
  - 001 SH: writes halfword lane address[1] with write_data[15:0].
  - 010 SW: writes the full word.
  - Any other code: no write. Unwritten lanes are always preserved.
- Loads, by funct3:
  - 000 LB and 100 LBU: selected byte, sign- or zero-extended.
  - 001 LH and 101 LHU: selected halfword, sign- or zero-extended.
  - 010 LW: full word.
  - Any other code: 0.
- read_data=0 whenever MemRead=0 or mem_busy=1.
- Misalignment:
  - Halfword access with address[0]=1, or word access with address[1:0]≠0.
  - misaligned=1 only while MemRead or MemWrite is high.
  - A misaligned store writes nothing; a misaligned load returns 0.
- dbg_req_ready = (state==IDLE) & dbg_enable & ~MemWrite. The CPU has priority.
- Debug accept (valid & ready on an edge):
  - A write updates the full word mem[dbg_addr].
  - A read captures mem[dbg_addr].
  - resp_addr, resp_data and resp_err are latched and the FSM goes to RESP.
  - If dbg_addr ≥ DEPTH: no write occurs, resp_data=0, resp_err=1.
- RESP: dbg_resp_valid=1 and the response fields are held stable. On dbg_resp_valid & dbg_resp_ready the FSM returns to IDLE.
- Asserting reset_n low at any time (mid-sweep, in RESP) immediately:
  - drops dbg_resp_valid;
  - clears the response registers;
  - restarts from CLEAR with clr_cnt=0.

## Timing
- Reset values:
  - dbg_resp_valid=0, dbg_resp_addr=0, dbg_resp_data=0, dbg_resp_err=0, dbg_req_ready=0.
  - mem_busy=CLEAR_ON_RESET; clr_cnt=0.
- Clear sweep: exactly DEPTH cycles after reset_n rises. mem_busy falls after the edge that writes index DEPTH-1.
- CPU load: zero latency; read_data reflects address and funct3 in the same cycle.
- CPU store: committed at the rising edge; a load of the same word in the next cycle sees the new value.
- Debug:
  - The request is accepted at edge N; dbg_resp_valid is high from N+1.
  - The earliest next acceptance is the edge after the response handshake.
  - Back-to-back throughput is therefore one request per 2 cycles.
- A debug read captures memory as of edge N. CPU writes cannot coincide, because ready=0 while MemWrite=1.
- dbg_enable falling while in RESP does not cancel the pending response.

## Test plan
- Reset sweep, DEPTH=16:
  - Preload random contents, pulse reset_n low.
  - mem_busy is high for 16 cycles, then low.
  - LW of every word returns 0x00000000; data_mem0=0.
- Byte/half stores:
  - SW 0x11223344 @0x8, then SB 0xAA @0x9, then SH 0xBEEF @0xA.
  - LW @0x8 = 0xBEEFAA44.
  - LB @0x9 = 0xFFFFFFAA; LBU @0x9 = 0x000000AA; LH @0xA = 0xFFFFBEEF.
- Misalignment:
  - SW 0x12345678 @0x6: misaligned=1 and the word is unchanged.
  - LH @0x5: misaligned=1, read_data=0.
  - LB @0x5: misaligned=0.
- Debug handshake:
  - dbg_enable=1, write 0xCAFEF00D @addr 3, hold dbg_resp_ready=0 for 3 cycles: resp stays valid with addr=3, data=0xCAFEF00D.
  - Then read addr 3: returns 0xCAFEF00D, err=0.
- Arbitration and errors:
  - MemWrite=1 with dbg_req_valid=1: ready=0 and the CPU write lands.
  - dbg_enable=0: never accepted.
  - dbg_addr=DEPTH: resp_err=1, data=0, memory unchanged.
- Reset mid-operation:
  - reset_n low while in RESP and during the sweep at clr_cnt=5.
  - resp_valid drops at once; the sweep restarts at 0 and takes the full DEPTH cycles.
